// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state types, constants and bit-timing helper for uart_fifo_ctrl
package uart_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int OVERSAMPLE  = 8;
  localparam int CNT_W       = 19;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Clocks per serial bit; a prescale of 0 is treated as 1.
  function automatic logic [CNT_W-1:0] bit_clocks(input logic [15:0] prescale);
    logic [15:0] p;
    p = (prescale == 16'd0) ? 16'd1 : prescale;
    return CNT_W'(p) * CNT_W'(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with full/empty/level; push when full and pop when empty are ignored
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + LW'(1);
      else if (do_pop && !do_push) count_q <= count_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - full-duplex UART with TX/RX FIFOs, runtime frame format and sticky error flags
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  output logic                          tx_o,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [15:0]                   prescale_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  input  logic                          loopback_i,
  input  logic                          err_clr_i,
  output logic                          tx_busy_o,
  output logic                          rx_busy_o,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level_o,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overrun_err_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH-1);

  logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
  logic [DATA_WIDTH-1:0] tx_head;

  assign s_axis_tready = rst_ni & ~tx_full;
  assign m_axis_tvalid = ~rx_empty;

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i, .rst_ni, .push_i(s_axis_tvalid & s_axis_tready), .wdata_i(s_axis_tdata),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level_o)
  );

  tx_state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
  logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_two_stop_q, tx_two_stop_d;
  logic tx_stop2_q, tx_stop2_d, tx_q, tx_d, tx_start, tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_len_q - CNT_W'(1));
  assign tx_o       = loopback_i ? 1'b1 : tx_q;
  assign tx_busy_o  = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;  tx_cnt_d = tx_cnt_q + CNT_W'(1);  tx_len_d = tx_len_q;
    tx_bit_d = tx_bit_q;  tx_shift_d = tx_shift_q;  tx_par_d = tx_par_q;
    tx_par_en_d = tx_par_en_q;  tx_two_stop_d = tx_two_stop_q;  tx_stop2_d = tx_stop2_q;
    tx_d = tx_q;  tx_pop = 1'b0;  tx_start = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (!tx_empty) tx_start = 1'b1;
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d = '0;  tx_state_d = TX_DATA;  tx_d = tx_shift_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
          tx_d       = tx_par_en_q ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + BIT_W'(1);
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_cnt_d = '0;  tx_state_d = TX_STOP;  tx_d = 1'b1;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_two_stop_q && !tx_stop2_q) tx_stop2_d = 1'b1;
        else if (!tx_empty)               tx_start   = 1'b1;
        else                              tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Launching straight from STOP keeps back-to-back frames gap-free.
    if (tx_start) begin
      tx_pop = 1'b1;  tx_state_d = TX_START;  tx_cnt_d = '0;  tx_d = 1'b0;  tx_bit_d = '0;
      tx_shift_d = tx_head;  tx_par_d = ^tx_head ^ parity_odd_i;  tx_len_d = bit_clocks(prescale_i);
      tx_par_en_d = parity_en_i;  tx_two_stop_d = two_stop_i;  tx_stop2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;  tx_cnt_q <= '0;  tx_len_q <= bit_clocks(16'd1);  tx_bit_q <= '0;
      tx_shift_q <= '0;  tx_par_q <= 1'b0;  tx_par_en_q <= 1'b0;  tx_two_stop_q <= 1'b0;
      tx_stop2_q <= 1'b0;  tx_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_len_q <= tx_len_d;  tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;  tx_par_q <= tx_par_d;  tx_par_en_q <= tx_par_en_d;
      tx_two_stop_q <= tx_two_stop_d;  tx_stop2_q <= tx_stop2_d;  tx_q <= tx_d;
    end
  end

  rx_state_e             rx_state_q, rx_state_d;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic rx_line, rx_prev_q, rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic rx_par_bad_q, rx_par_bad_d, rx_bit_end, set_frame, set_parity, set_overrun;

  assign rx_line    = loopback_i ? tx_q : rx_sync_q[SYNC_STAGES-1];
  assign rx_bit_end = (rx_cnt_q == rx_len_q - CNT_W'(1));
  assign rx_busy_o  = (rx_state_q != RX_IDLE);

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i, .rst_ni, .push_i(rx_push), .wdata_i(rx_shift_q),
    .pop_i(m_axis_tvalid & m_axis_tready), .rdata_o(m_axis_tdata), .full_o(rx_full),
    .empty_o(rx_empty), .level_o(rx_level_o)
  );

  always_comb begin
    rx_state_d = rx_state_q;  rx_cnt_d = rx_cnt_q + CNT_W'(1);  rx_len_d = rx_len_q;
    rx_bit_d = rx_bit_q;  rx_shift_d = rx_shift_q;  rx_par_en_d = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;  rx_par_bad_d = rx_par_bad_q;
    rx_push = 1'b0;  set_frame = 1'b0;  set_parity = 1'b0;  set_overrun = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_line) begin
          rx_state_d = RX_START;  rx_len_d = bit_clocks(prescale_i);
          rx_par_en_d = parity_en_i;  rx_par_odd_d = parity_odd_i;  rx_par_bad_d = 1'b0;
        end
      end
      RX_START: if (rx_cnt_q == (rx_len_q >> 1) - CNT_W'(1)) begin
        rx_cnt_d = '0;  rx_bit_d = '0;
        rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_line, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
        else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_cnt_d = '0;  rx_state_d = RX_STOP;
        if (rx_line != (^rx_shift_q ^ rx_par_odd_q)) begin
          rx_par_bad_d = 1'b1;  set_parity = 1'b1;
        end
      end
      // Leave at mid-stop so the next start edge is caught even with baud skew.
      RX_STOP: if (rx_bit_end) begin
        rx_cnt_d = '0;  rx_state_d = RX_IDLE;
        if (!rx_line)          set_frame   = 1'b1;
        else if (rx_par_bad_q) rx_push     = 1'b0;
        else if (rx_full)      set_overrun = 1'b1;
        else                   rx_push     = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_sync_q <= '1;  rx_prev_q <= 1'b1;  rx_state_q <= RX_IDLE;  rx_cnt_q <= '0;
      rx_len_q <= bit_clocks(16'd1);  rx_bit_q <= '0;  rx_shift_q <= '0;
      rx_par_en_q <= 1'b0;  rx_par_odd_q <= 1'b0;  rx_par_bad_q <= 1'b0;
      frame_err_o <= 1'b0;  parity_err_o <= 1'b0;  overrun_err_o <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx_i};  rx_prev_q <= rx_line;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_len_q <= rx_len_d;
      rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;  rx_par_en_q <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;  rx_par_bad_q <= rx_par_bad_d;
      frame_err_o   <= set_frame   | (frame_err_o   & ~err_clr_i);
      parity_err_o  <= set_parity  | (parity_err_o  & ~err_clr_i);
      overrun_err_o <= set_overrun | (overrun_err_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - scoreboard bench for uart_fifo_ctrl
module tb_uart_fifo_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0, rx_i = 1'b1, tx_o;
  logic [7:0] s_axis_tdata = '0, m_axis_tdata;
  logic       s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b0;
  logic [15:0] prescale_i = 16'd1;
  logic       parity_en_i = 1'b0, parity_odd_i = 1'b0, two_stop_i = 1'b0;
  logic       loopback_i = 1'b0, err_clr_i = 1'b0;
  logic       tx_busy_o, rx_busy_o, frame_err_o, parity_err_o, overrun_err_o;
  logic [4:0] tx_level_o, rx_level_o;

  int checks = 0;
  int errors = 0;
  int bit_clks = 8;
  logic [7:0] byte_q[$];
  logic       bit_q[$];

  always #5 clk_i = ~clk_i;

  uart_fifo_ctrl #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .tx_o(tx_o),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .prescale_i(prescale_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .two_stop_i(two_stop_i), .loopback_i(loopback_i), .err_clr_i(err_clr_i),
    .tx_busy_o(tx_busy_o), .rx_busy_o(rx_busy_o), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overrun_err_o(overrun_err_o)
  );

  task automatic do_reset();
    rst_ni = 1'b0;  s_axis_tvalid = 1'b0;  err_clr_i = 1'b0;  rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic axis_push(input logic [7:0] d);
    int ok;
    ok = 0;
    @(negedge clk_i);
    s_axis_tdata = d;  s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (s_axis_tready) begin ok = 1; break; end
      @(negedge clk_i);
    end
    checks++;
    if (ok == 0) begin errors++; $display("FAIL push_timeout got tready=0 want 1"); end
    @(posedge clk_i);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
    rx_i = 1'b0;  repeat (bit_clks) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin rx_i = d[i]; repeat (bit_clks) @(negedge clk_i); end
    if (pe) begin rx_i = pb; repeat (bit_clks) @(negedge clk_i); end
    rx_i = sb;    repeat (bit_clks) @(negedge clk_i);
    rx_i = 1'b1;  repeat (bit_clks) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx_o got %b want 1", tx_o); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if ({tx_level_o, rx_level_o} !== 10'd0) begin errors++; $display("FAIL reset_levels got %0d/%0d want 0/0", tx_level_o, rx_level_o); end
    checks++; if ({frame_err_o, parity_err_o, overrun_err_o, tx_busy_o, rx_busy_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {frame_err_o, parity_err_o, overrun_err_o, tx_busy_o, rx_busy_o}); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", s_axis_tready); end
  endtask

  // Two frames back to back: 0xA5 then 0x3C, every clock of both frames checked.
  task automatic test_tx_pattern();
    logic [7:0] data [2];
    logic e;
    int found;
    data[0] = 8'hA5;  data[1] = 8'h3C;
    do_reset();
    prescale_i = 16'd1;  parity_en_i = 1'b0;  two_stop_i = 1'b0;  loopback_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) bit_q.push_back(data[k][i]);
      bit_q.push_back(1'b1);
    end
    fork
      begin axis_push(data[0]); axis_push(data[1]); end
      begin
        found = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk_i);
          if (tx_o === 1'b0) begin found = 1; break; end
        end
        checks++; if (found == 0) begin errors++; $display("FAIL tx_start_timeout got tx_o=%b want 0", tx_o); end
        while (found != 0 && bit_q.size() > 0) begin
          e = bit_q.pop_front();
          for (int c = 0; c < 8; c++) begin
            checks++; if (tx_o !== e || tx_busy_o !== 1'b1) begin
              errors++; $display("FAIL tx_bit got tx_o=%b busy=%b want tx_o=%b busy=1", tx_o, tx_busy_o, e); end
            @(negedge clk_i);
          end
        end
        checks++; if (tx_busy_o !== 1'b0 || tx_o !== 1'b1) begin
          errors++; $display("FAIL tx_end got busy=%b tx_o=%b want 0/1", tx_busy_o, tx_o); end
      end
    join
    bit_q.delete();
  endtask

  task automatic test_loopback();
    int got;
    do_reset();
    prescale_i = 16'd1;  parity_en_i = 1'b1;  parity_odd_i = 1'b0;  two_stop_i = 1'b1;
    loopback_i = 1'b1;  m_axis_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin byte_q.push_back(8'(i)); axis_push(8'(i)); end
      end
      begin
        got = 0;
        for (int c = 0; c < 4000 && got < 16; c++) begin
          @(negedge clk_i);
          if (m_axis_tvalid) begin
            checks++;
            if (byte_q.size() == 0) begin errors++; $display("FAIL loop_extra got %h want none", m_axis_tdata); end
            else if (m_axis_tdata !== byte_q[0]) begin errors++; $display("FAIL loop_data got %h want %h", m_axis_tdata, byte_q[0]); end
            if (byte_q.size() != 0) void'(byte_q.pop_front());
            checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL loop_tx_o got %b want 1", tx_o); end
            got++;
          end
        end
        checks++; if (got != 16) begin errors++; $display("FAIL loop_count got %0d want 16", got); end
      end
    join
    checks++; if (parity_err_o !== 1'b0 || frame_err_o !== 1'b0) begin
      errors++; $display("FAIL loop_errs got p=%b f=%b want 0/0", parity_err_o, frame_err_o); end
    byte_q.delete();
    loopback_i = 1'b0;  two_stop_i = 1'b0;  m_axis_tready = 1'b0;
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic pb;
    do_reset();
    prescale_i = 16'd2;  bit_clks = 16;  parity_en_i = 1'b1;  parity_odd_i = 1'b1;  m_axis_tready = 1'b0;
    d = 8'h3C;
    pb = ^d ^ 1'b1;
    byte_q.push_back(d);
    send_rx(d, 1'b1, pb, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== byte_q[0]) begin
      errors++; $display("FAIL par_good got v=%b d=%h want 1/%h", m_axis_tvalid, m_axis_tdata, byte_q[0]); end
    void'(byte_q.pop_front());
    m_axis_tready = 1'b1;  @(negedge clk_i);  m_axis_tready = 1'b0;
    send_rx(d, 1'b1, ~pb, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b0 || rx_level_o !== 5'd0) begin
      errors++; $display("FAIL par_bad_push got v=%b lvl=%0d want 0/0", m_axis_tvalid, rx_level_o); end
    checks++; if (parity_err_o !== 1'b1 || frame_err_o !== 1'b0) begin
      errors++; $display("FAIL par_flag got p=%b f=%b want 1/0", parity_err_o, frame_err_o); end
    err_clr_i = 1'b1;  @(negedge clk_i);  err_clr_i = 1'b0;
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_clear got %b want 0", parity_err_o); end
    parity_en_i = 1'b0;  parity_odd_i = 1'b0;  prescale_i = 16'd1;  bit_clks = 8;
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    int got;
    do_reset();
    prescale_i = 16'd1;  bit_clks = 8;  m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom_range(255, 0));
      if (i < 16) byte_q.push_back(d);
      send_rx(d, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (rx_level_o !== 5'd16) begin errors++; $display("FAIL ovr_level got %0d want 16", rx_level_o); end
    checks++; if (overrun_err_o !== 1'b1 || frame_err_o !== 1'b0) begin
      errors++; $display("FAIL ovr_flag got o=%b f=%b want 1/0", overrun_err_o, frame_err_o); end
    m_axis_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && m_axis_tvalid; c++) begin
      checks++;
      if (byte_q.size() == 0) begin errors++; $display("FAIL ovr_extra got %h want none", m_axis_tdata); end
      else begin
        if (m_axis_tdata !== byte_q[0]) begin errors++; $display("FAIL ovr_data got %h want %h", m_axis_tdata, byte_q[0]); end
        void'(byte_q.pop_front());
      end
      got++;
      @(negedge clk_i);
    end
    checks++; if (got != 16 || rx_level_o !== 5'd0) begin
      errors++; $display("FAIL ovr_drain got %0d/%0d want 16/0", got, rx_level_o); end
    byte_q.delete();
    m_axis_tready = 1'b0;
  endtask

  task automatic test_glitch_frame();
    do_reset();
    prescale_i = 16'd0;  bit_clks = 8;  m_axis_tready = 1'b0;
    rx_i = 1'b0;  repeat (2) @(negedge clk_i);  rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    checks++; if (rx_busy_o !== 1'b0 || rx_level_o !== 5'd0) begin
      errors++; $display("FAIL glitch_push got busy=%b lvl=%0d want 0/0", rx_busy_o, rx_level_o); end
    checks++; if ({frame_err_o, parity_err_o, overrun_err_o} !== 3'b000) begin
      errors++; $display("FAIL glitch_err got %b want 000", {frame_err_o, parity_err_o, overrun_err_o}); end
    send_rx(8'h81, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_err_o !== 1'b1 || rx_level_o !== 5'd0) begin
      errors++; $display("FAIL frame_err got f=%b lvl=%0d want 1/0", frame_err_o, rx_level_o); end
    byte_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== byte_q[0]) begin
      errors++; $display("FAIL prescale0_rx got v=%b d=%h want 1/%h", m_axis_tvalid, m_axis_tdata, byte_q[0]); end
    void'(byte_q.pop_front());
    prescale_i = 16'd1;
  endtask

  task automatic test_reset_mid_tx();
    int found;
    do_reset();
    prescale_i = 16'd1;  parity_en_i = 1'b0;  two_stop_i = 1'b0;  loopback_i = 1'b0;
    fork
      begin axis_push(8'h11); axis_push(8'h22); axis_push(8'h33); end
      begin
        found = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk_i);
          if (tx_o === 1'b0) begin found = 1; break; end
        end
        checks++; if (found == 0) begin errors++; $display("FAIL rst_tx_start got tx_o=%b want 0", tx_o); end
        repeat (34) @(negedge clk_i);
        checks++; if (tx_level_o !== 5'd2 || tx_busy_o !== 1'b1) begin
          errors++; $display("FAIL rst_pre got lvl=%0d busy=%b want 2/1", tx_level_o, tx_busy_o); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++; if (tx_o !== 1'b1 || tx_level_o !== 5'd0 || s_axis_tready !== 1'b0) begin
          errors++; $display("FAIL rst_mid got tx_o=%b lvl=%0d rdy=%b want 1/0/0", tx_o, tx_level_o, s_axis_tready); end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (s_axis_tready !== 1'b1 || tx_busy_o !== 1'b0 || tx_o !== 1'b1) begin
          errors++; $display("FAIL rst_release got rdy=%b busy=%b tx_o=%b want 1/0/1", s_axis_tready, tx_busy_o, tx_o); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_tx_pattern();
    test_loopback();
    test_parity();
    test_overrun();
    test_glitch_frame();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
